// File: rtl/uart_rx_parity_check.sv
// uart_rx_parity_check: baud-rate UART receiver with parity check, retransmit flag and valid/ack hold register
module uart_rx_parity_check #(
  parameter int size       = 32,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic            CLK_Baudin,
  input  logic            RstRx_n,
  input  logic            SerialIn,
  input  logic            DataAck,
  output logic [size-1:0] DataOut,
  output logic            DataValid,
  output logic            Flag_out,
  output logic            FrameErr,
  output logic            Overrun,
  output logic            BusyRx
);
  localparam int CW = $clog2(size) + 1;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [size-1:0] shift_q, shift_d, data_q, data_d;
  logic            acc_q, acc_d, valid_q, valid_d, flag_q, flag_d;
  logic            ferr_q, ferr_d, ovr_q, ovr_d, busy_q;
  // state and datapath registers; reset discards any frame in progress
  always_ff @(posedge CLK_Baudin or negedge RstRx_n) begin
    if (!RstRx_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      acc_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      flag_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      flag_q  <= flag_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= state_d != IDLE;
    end
  end
  // next state: start bit, size data bits, parity (abort on error), stop
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = SerialIn ? IDLE : DATA;
      DATA:    state_d = (cnt_q == CW'(size - 1)) ? PARITY : DATA;
      PARITY:  state_d = (acc_q ^ SerialIn) ? IDLE : STOP;
      default: state_d = IDLE;
    endcase
  end
  // datapath and outputs; ack frees the hold register on any edge, a good stop bit may reload it
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = valid_q & ~DataAck;
    flag_d  = flag_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d  = SerialIn ? cnt_q : '0;
        acc_d  = SerialIn ? acc_q : PARITY_ODD;
        flag_d = SerialIn & flag_q;
      end
      DATA: begin
        shift_d = {SerialIn, shift_q[size-1:1]};
        acc_d   = acc_q ^ SerialIn;
        cnt_d   = (cnt_q == CW'(size - 1)) ? cnt_q : cnt_q + CW'(1);
      end
      PARITY: flag_d = acc_q ^ SerialIn;
      STOP: begin
        data_d  = (SerialIn && (!valid_q || DataAck)) ? shift_q : data_q;
        valid_d = SerialIn ? (valid_q | ~DataAck) | !valid_q : valid_d;
        ovr_d   = SerialIn & valid_q & ~DataAck;
        ferr_d  = ~SerialIn;
      end
      default: ;
    endcase
  end
  assign DataOut   = data_q;
  assign DataValid = valid_q;
  assign Flag_out  = flag_q;
  assign FrameErr  = ferr_q;
  assign Overrun   = ovr_q;
  assign BusyRx    = busy_q;
endmodule

// File: tb/tb_uart_rx_parity_check.sv
// tb_uart_rx_parity_check: frame-level reference model checked every cycle, plus literal spot checks
module tb_uart_rx_parity_check;
  localparam int W   = 32;
  localparam bit ODD = 1'b0;
  typedef enum {IDL, STA, DAT, PAR, STP} kind_t;
  logic clk = 1'b0, rst_n = 1'b0, ser = 1'b1, ack = 1'b0;
  logic [W-1:0] dout;
  logic dv, flag, ferr, ovr, busy;
  int n = 0, fails = 0, ferr_seen = 0, ovr_seen = 0;
  logic [W-1:0] e_data = '0, cur = '0, d;
  logic e_valid = 1'b0, e_flag = 1'b0, e_ferr = 1'b0, e_ovr = 1'b0, e_busy = 1'b0, p;

  uart_rx_parity_check #(.size(W), .PARITY_ODD(ODD)) dut (
    .CLK_Baudin(clk), .RstRx_n(rst_n), .SerialIn(ser), .DataAck(ack),
    .DataOut(dout), .DataValid(dv), .Flag_out(flag), .FrameErr(ferr),
    .Overrun(ovr), .BusyRx(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] a, input logic [W-1:0] e);
    n++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("DataOut", dout, e_data);
    chk("DataValid", W'(dv), W'(e_valid));
    chk("Flag_out", W'(flag), W'(e_flag));
    chk("FrameErr", W'(ferr), W'(e_ferr));
    chk("Overrun", W'(ovr), W'(e_ovr));
    chk("BusyRx", W'(busy), W'(e_busy));
    if (ferr === 1'b1) ferr_seen++;
    if (ovr === 1'b1) ovr_seen++;
  end

  task automatic bit_out(input logic b, input logic a, input kind_t k, input logic perr);
    logic was_valid;
    @(negedge clk);
    ser = b;
    ack = a;
    @(posedge clk);
    #1;
    was_valid = e_valid;
    e_ferr = 1'b0;
    e_ovr  = 1'b0;
    if (a) e_valid = 1'b0;
    case (k)
      STA: begin e_busy = 1'b1; e_flag = 1'b0; end
      PAR: begin e_flag = perr; e_busy = !perr; end
      STP: begin
        e_busy = 1'b0;
        if (!b) e_ferr = 1'b1;
        else if (!was_valid || a) begin e_data = cur; e_valid = 1'b1; end
        else e_ovr = 1'b1;
      end
      default: ;
    endcase
    ack = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] wd, input logic par, input logic stp, input logic ack_stop);
    logic perr;
    cur  = wd;
    perr = (^wd) ^ par ^ ODD;
    bit_out(1'b0, 1'b0, STA, 1'b0);
    for (int i = 0; i < W; i++) bit_out(wd[i], 1'b0, DAT, 1'b0);
    bit_out(par, 1'b0, PAR, perr);
    if (!perr) bit_out(stp, ack_stop, STP, 1'b0);
    bit_out(1'b1, 1'b0, IDL, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) bit_out(1'b1, 1'b0, IDL, 1'b0);
    cur = '1;
    bit_out(1'b0, 1'b0, STA, 1'b0);
    repeat (5) bit_out(1'b1, 1'b0, DAT, 1'b0);
    #1;
    rst_n = 1'b0;
    {e_valid, e_flag, e_ferr, e_ovr, e_busy} = '0;
    e_data = '0;
    #1;
    chk("rst_busy", W'(busy), '0);
    chk("rst_valid", W'(dv), '0);
    chk("rst_data", dout, '0);
    @(negedge clk);
    rst_n = 1'b1;
    bit_out(1'b1, 1'b0, IDL, 1'b0);
    send_frame(32'hA5A5_0F0F, 1'b0, 1'b1, 1'b0);
    chk("t2_data", dout, 32'hA5A5_0F0F);
    chk("t2_valid", W'(dv), W'(1));
    chk("t2_flag", W'(flag), '0);
    bit_out(1'b1, 1'b1, IDL, 1'b0);
    send_frame(32'hA5A5_0F0F, 1'b1, 1'b1, 1'b0);
    chk("t3_flag", W'(flag), W'(1));
    chk("t3_valid", W'(dv), '0);
    chk("t3_data", dout, 32'hA5A5_0F0F);
    send_frame(32'h1, 1'b1, 1'b0, 1'b0);
    chk("t4_ferr_pulses", W'(ferr_seen), W'(1));
    chk("t4_data", dout, 32'hA5A5_0F0F);
    chk("t4_flag", W'(flag), '0);
    send_frame(32'h1, 1'b1, 1'b1, 1'b0);
    send_frame(32'h2, 1'b1, 1'b1, 1'b0);
    chk("t5_ovr_pulses", W'(ovr_seen), W'(1));
    chk("t5_data_kept", dout, 32'h1);
    send_frame(32'h2, 1'b1, 1'b1, 1'b1);
    chk("t5_ovr_after_ack", W'(ovr_seen), W'(1));
    chk("t5_data_new", dout, 32'h2);
    chk("t5_valid", W'(dv), W'(1));
    bit_out(1'b1, 1'b1, IDL, 1'b0);
    d = 32'hDEAD_BEEF;
    p = ^d;
    send_frame(d ^ 32'h20, p, 1'b1, 1'b0);
    chk("t6_flag_retx", W'(flag), W'(1));
    send_frame(d, p, 1'b1, 1'b0);
    chk("t6_flag_clr", W'(flag), '0);
    chk("t6_data", dout, 32'hDEAD_BEEF);
    bit_out(1'b1, 1'b1, IDL, 1'b0);
    bit_out(1'b1, 1'b1, IDL, 1'b0);
    chk("idle_ack_valid", W'(dv), '0);
    chk("idle_ack_data", dout, 32'hDEAD_BEEF);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n, fails);
    $finish;
  end
endmodule
